// File: rtl/hack_data_mem.sv
// hack_data_mem: Hack CPU data-memory responder (RAM, KBD, STATUS, screen FIFO).
// Ports:
//   clk, reset          clock; async active-high reset
//   addressM/outM/writeM CPU data bus request; inM combinational read data
//   kbd_strobe/kbd_code keyboard code load
//   scr_valid/addr/data screen-write FIFO head; scr_ready accepts it
module hack_data_mem #(
  parameter int RAM_AW  = 14,
  parameter int FIFO_AW = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic        kbd_strobe,
  input  logic [15:0] kbd_code,
  output logic        scr_valid,
  output logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  input  logic        scr_ready
);

  localparam int CW    = FIFO_AW + 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [14:0] a;
  logic        unused_a15;

  assign a          = addressM[14:0];
  assign unused_a15 = addressM[15];

  logic in_ram, in_scr, in_kbd, in_stat;

  assign in_ram  = (a[14] == 1'b0)
                 && ({1'b0, a[13:0]} < 15'(1 << RAM_AW));
  assign in_scr  = (a[14:13] == 2'b10);
  assign in_kbd  = (a == 15'h6000);
  assign in_stat = (a == 15'h6001);

  logic [15:0] ram_q [2**RAM_AW];
  logic [RAM_AW-1:0] ram_idx;

  assign ram_idx = a[RAM_AW-1:0];

  always_ff @(posedge clk) begin
    if (writeM && in_ram)
      ram_q[ram_idx] <= outM;
  end

  logic [15:0]        kbd_q, kbd_d;
  logic               ovf_q, ovf_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [12:0] fifo_addr_q [DEPTH];
  logic [15:0] fifo_data_q [DEPTH];

  logic push, pop, full, empty, push_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == DEPTH_C);
  assign push    = writeM && in_scr;
  assign pop     = scr_valid && scr_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push && (!full || pop);

  always_comb begin
    kbd_d    = kbd_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (kbd_strobe)
      kbd_d = kbd_code;
    if (push && !push_ok)
      ovf_d = 1'b1;
    else if (writeM && in_stat && outM[2])
      ovf_d = 1'b0;
    if (push_ok)
      wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)
      rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd_q    <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      kbd_q    <= kbd_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_addr_q[wr_ptr_q] <= a[12:0];
      fifo_data_q[wr_ptr_q] <= outM;
    end
  end

  assign scr_valid = !empty;
  assign scr_addr  = fifo_addr_q[rd_ptr_q];
  assign scr_data  = fifo_data_q[rd_ptr_q];

  logic [15:0] status;

  always_comb begin
    status          = '0;
    status[0]       = empty;
    status[1]       = full;
    status[2]       = ovf_q;
    status[4 +: CW] = cnt_q;
  end

  always_comb begin
    inM = '0;
    unique case (1'b1)
      in_ram:  inM = ram_q[ram_idx];
      in_kbd:  inM = kbd_q;
      in_stat: inM = status;
      default: inM = '0;
    endcase
  end

endmodule
